// File: rtl/data_ram.sv
// data_ram: MEM-stage word RAM with byte/half/word access and wait states; DATA_RAM_MISALIGN_EXC_EN rejects misaligned requests
module data_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYCLES = 1,
    localparam int ADDR_WIDTH = 32,
    localparam int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [3:0]            mem_op_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misalign_o
);
    localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LBU = 4'd4,
                           OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic done_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic req, is_st, is_b, is_h, is_w, is_sg, mis, acc, rej;
    logic [1:0] lane;
    logic [3:0] be;
    logic [31:0] wd, word, ld;
    logic [DEPTH_LOG2-1:0] idx;
    logic unused_ok;
    assign req = mem_op_i != OP_NOP;
    assign is_st = mem_op_i inside {OP_SB, OP_SH, OP_SW};
    assign is_b = mem_op_i inside {OP_LB, OP_LBU, OP_SB};
    assign is_h = mem_op_i inside {OP_LH, OP_LHU, OP_SH};
    assign is_w = !is_b && !is_h;
    assign is_sg = mem_op_i inside {OP_LB, OP_LH};
`ifdef DATA_RAM_MISALIGN_EXC_EN
    assign mis = (is_h && mem_addr_i[0]) || (is_w && mem_addr_i[1:0] != 2'b00);
    assign lane = mem_addr_i[1:0];
`else
    assign mis = 1'b0;
    assign lane = is_w ? 2'b00 : is_h ? {mem_addr_i[1], 1'b0} : mem_addr_i[1:0];
`endif
    assign idx = mem_addr_i[DEPTH_LOG2+1:2];
    assign word = mem_q[idx];
    assign ld = is_b ? {{24{is_sg & word[{lane, 3'b000} + 7]}}, word[{lane, 3'b000} +: 8]}
              : is_h ? {{16{is_sg & word[{lane[1], 4'b0000} + 15]}}, word[{lane[1], 4'b0000} +: 16]}
              : word;
    assign be = is_b ? 4'b0001 << lane : is_h ? 4'b0011 << lane : 4'b1111;
    assign wd = is_b ? {4{mem_data_i[7:0]}} : is_h ? {2{mem_data_i[15:0]}} : mem_data_i;
    assign acc = state_q == BUSY && cnt_q == 4'd0;
    assign rej = state_q == IDLE && req && mis;
    assign stall_o = !rst_i && (state_q == BUSY || (state_q == IDLE && req));
    assign done_o = done_q;
    assign rdata_o = rdata_q;
    assign unused_ok = ^{mem_we_i, mem_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2]};
    // next-state: wait-state countdown and misaligned short-cut to RESP
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                cnt_d = 4'(WAIT_CYCLES);
                state_d = mis ? RESP : BUSY;
            end
            BUSY: if (cnt_q == 4'd0) state_d = RESP; else cnt_d = cnt_q - 4'd1;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // control state, completion pulse and load result register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
            done_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            done_q <= state_d == RESP;
            if (acc && !is_st) rdata_q <= ld;
            else if (rej) rdata_q <= '0;
        end
    end
    // byte-lane store on the access edge, suppressed when reset coincides
    always_ff @(posedge clk_i) begin
        if (!rst_i && acc && is_st)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
    end
`ifdef DATA_RAM_MISALIGN_EXC_EN
    logic misalign_q;
    assign misalign_o = misalign_q;
    // misalign flag set on rejection, cleared by an aligned access
    always_ff @(posedge clk_i) begin
        if (rst_i) misalign_q <= 1'b0;
        else if (rej) misalign_q <= 1'b1;
        else if (acc) misalign_q <= 1'b0;
    end
`else
    assign misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: randomized and directed checks of data_ram against a byte-array memory model
module tb_data_ram;
    localparam int W = 1;
    logic clk_i = 1'b0, rst_i = 1'b1, mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0, mem_data_i = '0;
    logic [3:0] mem_op_i = 4'd0;
    logic stall_o, done_o, misalign_o;
    logic [31:0] rdata_o;
    int checks = 0, failures = 0;
    logic [7:0] mem_m [4096];
    logic [31:0] rdata_m = '0;
    logic [31:0] r;

    data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i), .mem_op_i(mem_op_i), .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int osz(input logic [3:0] op);
        return (op == 1 || op == 4 || op == 6) ? 1 : (op == 2 || op == 5 || op == 7) ? 2 : 4;
    endfunction

    // one request from an IDLE cycle through RESP, checked against the model
    task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        int sz, ea, cyc, stalls, exp_cyc;
        bit seen, mis;
        longint v;
        sz = osz(op);
        ea = int'(a % 4096);
        mis = 0;
        if (ea % sz != 0) begin
`ifdef DATA_RAM_MISALIGN_EXC_EN
            mis = 1;
`else
            ea = ea - ea % sz;
`endif
        end
        mem_op_i = op; mem_addr_i = a; mem_data_i = d; mem_we_i = 1'($urandom_range(0, 1));
        exp_cyc = mis ? 1 : W + 2;
        cyc = 0; stalls = 0; seen = 0;
        @(negedge clk_i);
        chk("done_pulse_end", {31'b0, done_o}, 32'd0);
        stalls += int'(stall_o); cyc++;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                chk("stall_in_resp", {31'b0, stall_o}, 32'd0);
            end else begin
                cyc++; stalls += int'(stall_o);
            end
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("done_latency", cyc, exp_cyc);
        chk("stall_cycles", stalls, exp_cyc);
        if (mis) rdata_m = '0;
        else if (op >= 6) begin
            for (int k = 0; k < sz; k++) mem_m[ea + k] = d[8*k +: 8];
        end else begin
            v = 0;
            for (int k = sz - 1; k >= 0; k--) v = v * 256 + longint'(mem_m[ea + k]);
            if ((op == 1 || op == 2) && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
            rdata_m = v[31:0];
        end
        chk("rdata", rdata_o, rdata_m);
        chk("misalign", {31'b0, misalign_o}, {31'b0, mis});
        rd = rdata_o;
        @(posedge clk_i); #1;
        mem_op_i = 4'd0;
    endtask

    initial begin
        mem_op_i = 4'd3;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; mem_op_i = 4'd0;
        @(negedge clk_i);
        chk("idle_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        for (int i = 0; i < 1024; i++) do_req(4'd8, 32'(i * 4), 32'd0, r);
        do_req(4'd8, 32'h10, 32'h8899AABB, r);
        do_req(4'd3, 32'h10, 32'h0, r);      chk("plan_lw", r, 32'h8899AABB);
        do_req(4'd6, 32'h11, 32'hCC, r);
        do_req(4'd3, 32'h10, 32'h0, r);      chk("plan_sb_lw", r, 32'h8899CCBB);
        do_req(4'd1, 32'h11, 32'h0, r);      chk("plan_lb", r, 32'hFFFFFFCC);
        do_req(4'd4, 32'h11, 32'h0, r);      chk("plan_lbu", r, 32'h000000CC);
        do_req(4'd7, 32'h12, 32'h7123, r);
        do_req(4'd2, 32'h12, 32'h0, r);      chk("plan_lh", r, 32'h00007123);
        do_req(4'd5, 32'h10, 32'h0, r);      chk("plan_lhu", r, 32'h0000CCBB);
        do_req(4'd2, 32'h10, 32'h0, r);      chk("plan_lh_neg", r, 32'hFFFFCCBB);
        do_req(4'd8, 32'h1000, 32'h12345678, r);
        do_req(4'd3, 32'h0, 32'h0, r);       chk("plan_wrap", r, 32'h12345678);
        do_req(4'd3, 32'h13, 32'h0, r);
`ifdef DATA_RAM_MISALIGN_EXC_EN
        chk("plan_mis_lw", r, 32'h0);
`else
        chk("plan_mis_lw", r, 32'h7123CCBB);
`endif
        do_req(4'd3, 32'h10, 32'h0, r);      chk("plan_ram_kept", r, 32'h7123CCBB);
        mem_op_i = 4'd8; mem_addr_i = 32'h20; mem_data_i = 32'hDEADBEEF;
        repeat (W + 1) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("midrst_stall", {31'b0, stall_o}, 32'd0);
        rst_i = 1'b0; mem_op_i = 4'd0; rdata_m = '0;
        @(negedge clk_i);
        chk("midrst_idle_stall", {31'b0, stall_o}, 32'd0);
        chk("midrst_done", {31'b0, done_o}, 32'd0);
        chk("midrst_rdata", rdata_o, 32'd0);
        @(posedge clk_i); #1;
        do_req(4'd3, 32'h20, 32'h0, r);      chk("plan_midrst_lw", r, 32'h0);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'h0000107F;
            do_req(4'($urandom_range(1, 8)), a, $urandom, r);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk_i);
                chk("gap_stall", {31'b0, stall_o}, 32'd0);
                chk("gap_done", {31'b0, done_o}, 32'd0);
                @(posedge clk_i); #1;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
